regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader.sv | 112 +++++++++++
 tb/tb_regfile_dump_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Debug/trace reader: walks a register range through the register file read port
// and streams {index, data} beats to a valid/ready sink, with a running count and sum.
module regfile_dump_reader #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [IW-1:0]   first_reg,
  input  logic [IW-1:0]   last_reg,
  output logic [IW-1:0]   rf_read_address,
  input  logic [XLEN-1:0] rf_read_data,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [IW-1:0]   dump_index,
  output logic [XLEN-1:0] dump_data,
  output logic            busy,
  output logic            done,
  output logic [IW:0]     word_count,
  output logic [XLEN-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] last_q;
  logic          handshake;

  assign handshake       = (state == S_SEND) && dump_valid && dump_ready;
  assign rf_read_address = (state == S_READ) ? idx : '0;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = (first_reg <= last_reg) ? S_READ : S_DONE;
        end
      end
      S_READ: state_next = S_SEND;
      S_SEND: begin
        if (handshake) begin
          state_next = (idx == last_q) ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      last_q     <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dump_index <= '0;
      dump_data  <= '0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      state      <= state_next;
      dump_valid <= (state_next == S_SEND);
      busy       <= (state_next != S_IDLE);
      done       <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            idx        <= first_reg;
            last_q     <= last_reg;
            word_count <= '0;
            checksum   <= '0;
          end
        end
        S_READ: begin
          if (!abort) begin
            dump_data  <= rf_read_data;
            dump_index <= idx;
          end
        end
        S_SEND: begin
          // A beat that handshakes alongside abort is dropped entirely.
          if (handshake && !abort) begin
            word_count <= word_count + {{IW{1'b0}}, 1'b1};
            checksum   <= checksum + dump_data;
            if (idx != last_q) begin
              idx <= idx + {{(IW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: behavioural register file plus a
// range-based expected-beat model, with randomized contents, ranges and sink stalls.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rf_read_address;
  logic [31:0] rf_read_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;
  logic [5:0]  word_count;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  regfile_dump_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .first_reg      (first_reg),
    .last_reg       (last_reg),
    .rf_read_address(rf_read_address),
    .rf_read_data   (rf_read_data),
    .dump_valid     (dump_valid),
    .dump_ready     (dump_ready),
    .dump_index     (dump_index),
    .dump_data      (dump_data),
    .busy           (busy),
    .done           (done),
    .word_count     (word_count),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, x0 hardwired to zero.
  assign rf_read_data = (rf_read_address == 5'd0) ? 32'd0 : rf[rf_read_address];

  function automatic logic [31:0] archRead(input int i);
    return (i == 0) ? 32'd0 : rf[i];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: three stall cycles per beat, 2: random ready
  task automatic applyStimulus(input int f, input int l, input int mode, input bit timed);
    logic [36:0] expQ [$];
    logic [36:0] gotQ [$];
    logic [31:0] expSum;
    logic [36:0] held;
    int          k;
    int          validRun;
    bit          prevStall;
    bit          sawDone;
    expSum    = 32'd0;
    validRun  = 0;
    prevStall = 1'b0;
    sawDone   = 1'b0;
    held      = '0;
    for (int i = f; i <= l; i++) begin
      expQ.push_back({5'(i), archRead(i)});
      expSum += archRead(i);
    end
    start     = 1'b1;
    first_reg = 5'(f);
    last_reg  = 5'(l);
    stepCycle();
    start = 1'b0;
    for (k = 1; k < 400; k++) begin
      if (k == 1) checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      if (prevStall && dump_valid) checkOutput("stall_hold", {27'd0, dump_index, dump_data}, {27'd0, held});
      case (mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (validRun >= 3);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (dump_valid && dump_ready) begin
        gotQ.push_back({dump_index, dump_data});
        validRun = 0;
      end else if (dump_valid) begin
        validRun++;
      end
      prevStall = dump_valid && !dump_ready;
      held      = {dump_index, dump_data};
      stepCycle();
    end
    checkOutput("done_seen", {63'd0, sawDone}, 64'd1);
    if (timed) checkOutput("done_cycle", 64'(k), (f <= l) ? 64'(2 * (l - f + 1) + 1) : 64'd1);
    checkOutput("beat_count", 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checkOutput("beat", {27'd0, gotQ[i]}, {27'd0, expQ[i]});
    end
    checkOutput("word_count", {58'd0, word_count}, 64'(expQ.size()));
    checkOutput("checksum", {32'd0, checksum}, {32'd0, expSum});
    dump_ready = 1'b0;
    stepCycle();
    checkOutput("done_pulse_end", {63'd0, done}, 64'd0);
    checkOutput("idle_after_done", {63'd0, busy}, 64'd0);
    checkOutput("count_hold", {58'd0, word_count}, 64'(expQ.size()));
  endtask

  // Abort lands on the handshake cycle of the second beat (cycle N+4).
  task automatic applyAbort(input int f, input int l);
    start     = 1'b1;
    first_reg = 5'(f);
    last_reg  = 5'(l);
    stepCycle();
    start      = 1'b0;
    dump_ready = 1'b1;
    repeat (3) stepCycle();
    checkOutput("abort_valid", {63'd0, dump_valid}, 64'd1);
    checkOutput("abort_index", {59'd0, dump_index}, 64'(f + 1));
    abort = 1'b1;
    stepCycle();
    abort      = 1'b0;
    dump_ready = 1'b0;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_valid_low", {63'd0, dump_valid}, 64'd0);
    checkOutput("abort_count", {58'd0, word_count}, 64'd1);
    checkOutput("abort_sum", {32'd0, checksum}, {32'd0, archRead(f)});
    repeat (2) begin
      stepCycle();
      checkOutput("abort_no_done", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, {63'd0, dump_valid}, 64'd0);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_addr"}, {59'd0, rf_read_address}, 64'd0);
    checkOutput({tag, "_index"}, {59'd0, dump_index}, 64'd0);
    checkOutput({tag, "_data"}, {32'd0, dump_data}, 64'd0);
    checkOutput({tag, "_count"}, {58'd0, word_count}, 64'd0);
    checkOutput({tag, "_sum"}, {32'd0, checksum}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f;
    int l;
    int mode;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    dump_ready = 1'b0;
    first_reg  = '0;
    last_reg   = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    repeat (3) stepCycle();
    checkAllZero("reset");
    rst = 1'b0;
    stepCycle();

    rf[1] = 32'h11;
    rf[2] = 32'h22;
    rf[3] = 32'hFFFF_FFF0;
    applyStimulus(0, 3, 0, 1'b1);
    checkOutput("preload_sum", {32'd0, checksum}, 64'h23);

    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    applyStimulus(5, 7, 1, 1'b0);
    applyStimulus(9, 4, 0, 1'b1);

    for (int i = 0; i < 32; i++) rf[i] = 32'h8000_0000;
    applyStimulus(0, 31, 2, 1'b0);
    checkOutput("wrap_sum", {32'd0, checksum}, 64'h8000_0000);

    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    applyAbort(0, 5);
    applyStimulus(0, 5, 0, 1'b1);
    applyAbort(3, 6);
    applyStimulus(31, 31, 0, 1'b1);
    applyStimulus(0, 0, 0, 1'b1);

    repeat (6) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      f    = $urandom_range(0, 31);
      l    = $urandom_range(0, 31);
      mode = $urandom_range(0, 2);
      applyStimulus(f, l, mode, mode == 0);
    end

    // Reset while a beat is pending in SEND.
    start     = 1'b1;
    first_reg = 5'd2;
    last_reg  = 5'd4;
    stepCycle();
    start      = 1'b0;
    dump_ready = 1'b0;
    stepCycle();
    checkOutput("pre_reset_valid", {63'd0, dump_valid}, 64'd1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkAllZero("mid_reset");
    start = 1'b1;
    abort = 1'b1;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_idle", {63'd0, busy}, 64'd0);
    stepCycle();
    checkOutput("start_abort_still_idle", {63'd0, busy}, 64'd0);
    checkOutput("start_abort_no_done", {63'd0, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
